sort_pipe: RTL

Parametrised, fully pipelined Batcher odd-even merge sorting network with valid/ready handshaking. Accepts one vector of N unsigned W-bit keys per cycle and emits it sorted a fixed number of cycles later, with a register after every comparator layer. It replaces the combinational fixed-size sorters where those miss timing. It sits between the stream producer and any consumer that can apply backpressure.

---
 rtl/sort_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sort_pipe.sv
// sort_pipe: fully pipelined Batcher odd-even merge sorting network.
// Sorts N unsigned W-bit keys per vector and puts a register after every
// comparator layer. A single global advance enable gives valid/ready
// backpressure, so the whole pipeline either shifts or holds.
// Optional feature macro: SORT_DESC_EN. When defined, in_desc is piped with
// each vector so that ascending and descending vectors can interleave. When
// undefined, every vector sorts ascending and in_desc is ignored.
module sort_pipe #(
    parameter int N = 32,
    parameter int W = 32,
    localparam int LOG_N = $clog2(N),
    localparam int L     = LOG_N * (LOG_N + 1) / 2,
    localparam int OW    = $clog2(L + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic            in_desc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic [OW-1:0]   occ
);

    // Layer numbering: merge size p = 2^pe runs through 1, 2, 4 .. N/2. For
    // each p, the comparator distance k runs through p, p/2 .. 1. A request
    // with want_k = 1 returns k, and otherwise it returns p.
    function automatic int layer_dist(input int layer, input bit want_k);
        int rem;
        int pe;
        rem = layer;
        pe  = 0;
        for (int e = 0; e < 8; e++) begin
            if (rem >= pe + 1) begin
                rem = rem - (pe + 1);
                pe  = pe + 1;
            end
        end
        return want_k ? ((1 << pe) >> rem) : (1 << pe);
    endfunction

    // Returns true when lane x is the low side of a comparator in this layer.
    // The partner lane is x + k.
    function automatic bit lane_is_lo(input int layer, input int x);
        int p;
        int k;
        int r;
        p = layer_dist(layer, 1'b0);
        k = layer_dist(layer, 1'b1);
        r = (k == p) ? 0 : k;
        return (x >= r) && (((x - r) % (2 * k)) < k) && ((x + k) < N) &&
               ((x / (2 * p)) == ((x + k) / (2 * p)));
    endfunction

    logic [W-1:0] r_data [L][N];
    logic [L-1:0] r_valid;
    logic [OW-1:0] r_occ;

    logic [W-1:0] w_src   [L][N];
    logic [W-1:0] w_layer [L][N];
    logic         w_valid_src [L];
    logic         w_desc_src  [L];
    logic         w_adv;
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic [OW-1:0] w_occ_next;

    assign w_adv      = !r_valid[L-1] || out_ready;
    assign w_in_xfer  = in_valid && w_adv;
    assign w_out_xfer = r_valid[L-1] && out_ready;

    assign in_ready  = w_adv;
    assign out_valid = r_valid[L-1];
    assign occ       = r_occ;

    // Comparator network. Each layer reads the previous stage register. The
    // first layer reads in_data directly.
    for (genvar s = 0; s < L; s++) begin : g_layer
        localparam int K = layer_dist(s, 1'b1);

        if (s == 0) begin : g_first
            assign w_valid_src[s] = in_valid;
            for (genvar x = 0; x < N; x++) begin : g_unpack
                assign w_src[s][x] = in_data[x*W +: W];
            end
        end else begin : g_next
            assign w_valid_src[s] = r_valid[s-1];
            for (genvar x = 0; x < N; x++) begin : g_unpack
                assign w_src[s][x] = r_data[s-1][x];
            end
        end

        for (genvar x = 0; x < N; x++) begin : g_lane
            if (lane_is_lo(s, x)) begin : g_lo
                logic w_swap;
                assign w_swap = w_desc_src[s] ? (w_src[s][x] < w_src[s][x+K])
                                              : (w_src[s][x] > w_src[s][x+K]);
                assign w_layer[s][x] = w_swap ? w_src[s][x+K] : w_src[s][x];
            end else if ((x >= K) && lane_is_lo(s, x - K)) begin : g_hi
                logic w_swap;
                assign w_swap = w_desc_src[s] ? (w_src[s][x-K] < w_src[s][x])
                                              : (w_src[s][x-K] > w_src[s][x]);
                assign w_layer[s][x] = w_swap ? w_src[s][x-K] : w_src[s][x];
            end else begin : g_pass
                assign w_layer[s][x] = w_src[s][x];
            end
        end
    end

`ifdef SORT_DESC_EN
    logic [L-1:0] r_desc;

    for (genvar s = 0; s < L; s++) begin : g_desc_src
        if (s == 0) begin : g_first
            assign w_desc_src[s] = in_desc;
        end else begin : g_next
            assign w_desc_src[s] = r_desc[s-1];
        end
    end

    // Sort-order bits travel alongside their vectors and shift on the same enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_desc <= '0;
        end else if (w_adv) begin
            for (int s = 0; s < L; s++) begin
                r_desc[s] <= w_desc_src[s];
            end
        end
    end
`else
    logic w_unused_desc;
    assign w_unused_desc = in_desc;

    for (genvar s = 0; s < L; s++) begin : g_desc_src
        assign w_desc_src[s] = 1'b0;
    end
`endif

    // Stage registers: every stage shifts one layer on advance and holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_occ   <= '0;
            // NOTE: the data registers are cleared on reset so that out_data reads 0
            // afterwards. Plain datapath storage would normally be left unreset.
            for (int s = 0; s < L; s++) begin
                for (int x = 0; x < N; x++) begin
                    r_data[s][x] <= '0;
                end
            end
        end else begin
            // NOTE: all state uses non-blocking assignments, so each stage
            // reads the value that its predecessor held before this edge.
            if (w_adv) begin
                for (int s = 0; s < L; s++) begin
                    r_valid[s] <= w_valid_src[s];
                    for (int x = 0; x < N; x++) begin
                        r_data[s][x] <= w_layer[s][x];
                    end
                end
            end
            r_occ <= w_occ_next;
        end
    end

    // Occupancy goes up on an input transfer and down on an output transfer.
    always_comb begin
        // NOTE: the default comes first, so every path assigns w_occ_next and no latch is inferred.
        w_occ_next = r_occ;
        if (w_in_xfer && !w_out_xfer) begin
            w_occ_next = r_occ + OW'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            w_occ_next = r_occ - OW'(1);
        end
    end

    // Pack the last stage back into the flat output lane layout.
    always_comb begin
        out_data = '0;
        for (int x = 0; x < N; x++) begin
            out_data[x*W +: W] = r_data[L-1][x];
        end
    end

endmodule
